// File: rtl/yc_testpat_gen_if.sv
// Video source bundle between the test-pattern generator (master) and the YC encoder (slave).
// Frame controls flow into the generator; timing and pixel data flow out.
interface yc_testpat_gen_if;
    logic        ce_pix;
    logic        pal_en;
    logic [2:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        csync;
    logic        de;
    logic        frame_start;

    modport master (
        input  ce_pix, pal_en, pattern_sel, solid_rgb,
        output rgb, hsync, vsync, csync, de, frame_start
    );

    modport slave (
        output ce_pix, pal_en, pattern_sel, solid_rgb,
        input  rgb, hsync, vsync, csync, de, frame_start
    );
endinterface

// File: rtl/yc_testpat_gen.sv
// 240p/288p timing and test-pattern source for the YC encoder; all outputs registered on ce_pix.
// Optional macro YC_TESTPAT_SCROLL_EN: per-frame counter scrolls the gray ramp pattern.
module yc_testpat_gen #(
    parameter int unsigned H_TOTAL       = 400,
    parameter int unsigned H_ACTIVE      = 320,
    parameter int unsigned H_FP          = 10,
    parameter int unsigned H_SYNC        = 30,
    parameter int unsigned V_ACTIVE_NTSC = 240,
    parameter int unsigned V_TOTAL_NTSC  = 262,
    parameter int unsigned V_ACTIVE_PAL  = 288,
    parameter int unsigned V_TOTAL_PAL   = 312,
    parameter int unsigned V_FP          = 3,
    parameter int unsigned V_SYNC        = 3,
    parameter int unsigned BAR_W         = 40
) (
    input logic             clk,
    input logic             reset,
    yc_testpat_gen_if.master vid
);

    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HAct    = 10'(H_ACTIVE);
    localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VActN   = 10'(V_ACTIVE_NTSC);
    localparam logic [9:0] VLastN  = 10'(V_TOTAL_NTSC - 1);
    localparam logic [9:0] VActP   = 10'(V_ACTIVE_PAL);
    localparam logic [9:0] VLastP  = 10'(V_TOTAL_PAL - 1);
    localparam logic [9:0] VFp     = 10'(V_FP);
    localparam logic [9:0] VSync   = 10'(V_SYNC);
    localparam logic [5:0] BarLast = 6'(BAR_W - 1);

    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [2:0]  r_bar_idx;
    logic [5:0]  r_bar_cnt;
    logic        r_pal;
    logic [2:0]  r_pat;

    logic [9:0]  w_vact;
    logic [9:0]  w_vlast;
    logic [9:0]  w_vs_start;
    logic        w_frame_start;
    logic        w_line_end;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic [2:0]  w_pat;
    logic [7:0]  w_scroll;
    logic [7:0]  w_gray;
    logic [7:0]  w_bar_lvl;
    logic [23:0] w_pix;

`ifdef YC_TESTPAT_SCROLL_EN
    logic [7:0] r_frame_cnt;

    // Advancing on the last pixel makes the new count visible from the first pixel of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (vid.ce_pix && w_line_end && (r_vcnt == w_vlast)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign w_scroll = r_frame_cnt;
`else
    assign w_scroll = 8'd0;
`endif

    always_comb begin
        w_vact        = r_pal ? VActP : VActN;
        w_vlast       = r_pal ? VLastP : VLastN;
        w_vs_start    = w_vact + VFp;
        w_frame_start = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
        w_line_end    = (r_hcnt == HLast);
        w_active      = (r_hcnt < HAct) && (r_vcnt < w_vact);
        w_hs          = (r_hcnt >= HsStart) && (r_hcnt < HsEnd);
        w_vs          = (r_vcnt >= w_vs_start) && (r_vcnt < (w_vs_start + VSync));
        // The first pixel of a frame already uses the selection being latched for that frame.
        w_pat         = w_frame_start ? vid.pattern_sel : r_pat;
    end

    always_comb begin
        w_bar_lvl = (w_pat == 3'd0) ? 8'hBF : 8'hFF;
        w_gray    = r_hcnt[8:1] + w_scroll;
        w_pix     = 24'h000000;
        case (w_pat)
            // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
            3'd0, 3'd1: w_pix = {r_bar_idx[1] ? 8'h00 : w_bar_lvl,
                                 r_bar_idx[2] ? 8'h00 : w_bar_lvl,
                                 r_bar_idx[0] ? 8'h00 : w_bar_lvl};
            3'd2:       w_pix = {w_gray, w_gray, w_gray};
            3'd3:       w_pix = vid.solid_rgb;
            3'd4:       w_pix = ((r_hcnt[3:0] == 4'd0) || (r_vcnt[3:0] == 4'd0)) ?
                                24'hFFFFFF : 24'h000000;
            3'd5:       w_pix = (r_hcnt[4] ^ r_vcnt[4]) ? 24'hFFFFFF : 24'h000000;
            default:    w_pix = 24'h000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt          <= 10'd0;
            r_vcnt          <= 10'd0;
            r_bar_idx       <= 3'd0;
            r_bar_cnt       <= 6'd0;
            r_pal           <= 1'b0;
            r_pat           <= 3'd0;
            vid.rgb         <= 24'h000000;
            vid.hsync       <= 1'b0;
            vid.vsync       <= 1'b0;
            vid.csync       <= 1'b0;
            vid.de          <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (vid.ce_pix) begin
            if (w_frame_start) begin
                r_pal <= vid.pal_en;
                r_pat <= vid.pattern_sel;
            end

            if (w_line_end) begin
                r_hcnt    <= 10'd0;
                r_bar_idx <= 3'd0;
                r_bar_cnt <= 6'd0;
                r_vcnt    <= (r_vcnt == w_vlast) ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
                // Bar index tracks hcnt/BAR_W with a small counter instead of a divider.
                if (r_bar_cnt == BarLast) begin
                    r_bar_cnt <= 6'd0;
                    r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 6'd1;
                end
            end

            vid.rgb         <= w_active ? w_pix : 24'h000000;
            vid.de          <= w_active;
            vid.hsync       <= w_hs;
            vid.vsync       <= w_vs;
            vid.csync       <= w_hs ^ w_vs;
            vid.frame_start <= w_frame_start;
        end
    end

endmodule
